dmem_arbiter: RTL and testbench

- Shares the single-port 16-bit data memory between three requesters: the CPU MEM/WB stage, the CCD capture writer, and the neural-net accelerator.
- The CPU gets single-beat priority access. CCD and accelerator get locked bursts, arbitrated round-robin between themselves.
- A burst cap guarantees the CPU one slot every MAX_BURST DMA beats.
- Drives the CPU pipeline stall (feeds fetchdecode iStall) while a CPU access is held off.

---
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port 16-bit RAM between the CPU MEM/WB stage,
// the CCD capture writer and the neural-net accelerator. The CPU gets single-beat priority;
// CCD and accelerator get locked bursts, round-robin between themselves, with a burst cap
// that forces the CPU in after MAX_BURST DMA beats while it waits.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 8   // 1..255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,

  input  logic              ccd_req,
  input  logic              ccd_last,
  input  logic [ADDR_W-1:0] ccd_addr,
  input  logic [DATA_W-1:0] ccd_wdata,
  output logic              ccd_gnt,

  input  logic              acc_req,
  input  logic              acc_we,
  input  logic              acc_last,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StBurstCcd = 2'd1;
  localparam logic [1:0] StBurstAcc = 2'd2;

  // Round-robin pointer: names the DMA port preferred on the next tie in idle.
  localparam logic RrCcd = 1'b0;
  localparam logic RrAcc = 1'b1;

  localparam logic [7:0] CntMax = 8'(MAX_BURST);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;
  logic       cpu_rvalid_q, acc_rvalid_q;

  logic       cpu_gnt_c, ccd_gnt_c, acc_gnt_c;
  logic       own_ccd, own_req, own_last;

  // Burst owner's request view, shared by both burst states.
  always_comb begin
    own_ccd  = (state_q == StBurstCcd);
    own_req  = own_ccd ? ccd_req  : acc_req;
    own_last = own_ccd ? ccd_last : acc_last;
  end

  // Arbitration and next-state: grants depend only on registered state and current requests.
  always_comb begin
    cpu_gnt_c = 1'b0;
    ccd_gnt_c = 1'b0;
    acc_gnt_c = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;

    case (state_q)
      StIdle: begin
        if (cpu_req) begin
          cpu_gnt_c = 1'b1;
        end else if (ccd_req && (!acc_req || (rr_q == RrCcd))) begin
          ccd_gnt_c = 1'b1;
          if (ccd_last) begin
            rr_d = RrAcc;
          end else begin
            state_d = StBurstCcd;
            cnt_d   = 8'd1;
          end
        end else if (acc_req) begin
          acc_gnt_c = 1'b1;
          if (acc_last) begin
            rr_d = RrCcd;
          end else begin
            state_d = StBurstAcc;
            cnt_d   = 8'd1;
          end
        end
      end

      StBurstCcd, StBurstAcc: begin
        if ((cnt_q == CntMax) && cpu_req) begin
          // Cap reached: CPU is forced in, the owner holds its pending beat.
          cpu_gnt_c = 1'b1;
          cnt_d     = 8'd0;
        end else if (own_req) begin
          ccd_gnt_c = own_ccd;
          acc_gnt_c = !own_ccd;
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (own_last) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            rr_d    = own_ccd ? RrAcc : RrCcd;
          end
        end else if (cpu_req) begin
          // Owner is in a gap; the CPU slips in without touching the cap count.
          cpu_gnt_c = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rr_q    <= RrCcd;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Read-valid flags track the 1-cycle synchronous RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_q <= 1'b0;
      acc_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt_c & ~cpu_we;
      acc_rvalid_q <= acc_gnt_c & ~acc_we;
    end
  end

  // Memory-side mux: the granted port drives the RAM; all zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt_c) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ccd_gnt_c) begin
      mem_we    = 1'b1;
      mem_addr  = ccd_addr;
      mem_wdata = ccd_wdata;
    end else if (acc_gnt_c) begin
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
    end
  end

  assign cpu_gnt    = cpu_gnt_c;
  assign ccd_gnt    = ccd_gnt_c;
  assign acc_gnt    = acc_gnt_c;
  assign mem_en     = cpu_gnt_c | ccd_gnt_c | acc_gnt_c;
  assign cpu_stall  = cpu_req & ~cpu_gnt_c;
  assign cpu_rvalid = cpu_rvalid_q;
  assign acc_rvalid = acc_rvalid_q;

  // Read data passes straight through from the RAM; kept as a named hook for the rvalid users.
  logic [DATA_W-1:0] rdata_unused;
  assign rdata_unused = mem_rdata;

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cpu_gnt_c, ccd_gnt_c, acc_gnt_c}));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural arbitration model checked every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_dmem_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;

  logic        ccd_req = 1'b0, ccd_last = 1'b0;
  logic [15:0] ccd_addr = '0, ccd_wdata = '0;
  logic        ccd_gnt;

  logic        acc_req = 1'b0, acc_we = 1'b0, acc_last = 1'b0;
  logic [15:0] acc_addr = '0, acc_wdata = '0;
  logic        acc_gnt, acc_rvalid;

  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_stall (cpu_stall),
    .ccd_req   (ccd_req),
    .ccd_last  (ccd_last),
    .ccd_addr  (ccd_addr),
    .ccd_wdata (ccd_wdata),
    .ccd_gnt   (ccd_gnt),
    .acc_req   (acc_req),
    .acc_we    (acc_we),
    .acc_last  (acc_last),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .acc_gnt   (acc_gnt),
    .acc_rvalid(acc_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [15:0] init_val(int i);
    return (i == 16) ? 16'h1234 : 16'((i * 257) ^ 16'h5a5a);
  endfunction

  // External single-port RAM with 1-cycle read latency, reloaded while in reset.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: owner 0 = none, 2 = CCD, 3 = ACC; who 1 = CPU, 2 = CCD, 3 = ACC.
  int          m_owner, m_run, m_rr, m_who;
  bit          m_cpu_rv, m_acc_rv, o_req, o_last, e_we;
  logic [15:0] m_rd, e_addr, e_wdata;
  logic [15:0] ref_mem [256];
  bit          g_cpu, g_ccd, g_acc;

  // Compare process: decide who must be served this cycle, check the DUT, advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_run = 0; m_rr = 2; m_cpu_rv = 0; m_acc_rv = 0;
      g_cpu = 0; g_ccd = 0; g_acc = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      chk("rst_gnt", 32'({cpu_gnt, ccd_gnt, acc_gnt}), 32'd0);
      chk("rst_rvalid", 32'({cpu_rvalid, acc_rvalid}), 32'd0);
    end else begin
      m_who = 0;
      if (m_owner == 0) begin
        if (cpu_req)                m_who = 1;
        else if (ccd_req && acc_req) m_who = m_rr;
        else if (ccd_req)            m_who = 2;
        else if (acc_req)            m_who = 3;
        if (m_who >= 2) begin
          if ((m_who == 2) ? ccd_last : acc_last) m_rr = (m_who == 2) ? 3 : 2;
          else begin m_owner = m_who; m_run = 1; end
        end
      end else begin
        o_req  = (m_owner == 2) ? ccd_req  : acc_req;
        o_last = (m_owner == 2) ? ccd_last : acc_last;
        if (m_run >= MAXB && cpu_req) begin
          m_who = 1; m_run = 0;
        end else if (o_req) begin
          m_who = m_owner; m_run++;
          if (o_last) begin m_rr = (m_owner == 2) ? 3 : 2; m_owner = 0; end
        end else if (cpu_req) begin
          m_who = 1;
        end
      end

      e_we = 0; e_addr = '0; e_wdata = '0;
      case (m_who)
        1: begin e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end
        2: begin e_we = 1'b1;   e_addr = ccd_addr; e_wdata = ccd_wdata; end
        3: begin e_we = acc_we; e_addr = acc_addr; e_wdata = acc_wdata; end
        default: ;
      endcase

      chk("cpu_gnt",   32'(cpu_gnt),   32'(m_who == 1));
      chk("ccd_gnt",   32'(ccd_gnt),   32'(m_who == 2));
      chk("acc_gnt",   32'(acc_gnt),   32'(m_who == 3));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && m_who != 1));
      chk("mem_en",    32'(mem_en),    32'(m_who != 0));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
      chk("acc_rvalid", 32'(acc_rvalid), 32'(m_acc_rv));
      if (m_cpu_rv || m_acc_rv) chk("rdata", 32'(mem_rdata), 32'(m_rd));

      if (m_who != 0 && e_we) ref_mem[e_addr[7:0]] = e_wdata;
      m_cpu_rv = (m_who == 1) && !cpu_we;
      m_acc_rv = (m_who == 3) && !acc_we;
      if (m_cpu_rv || m_acc_rv) m_rd = ref_mem[e_addr[7:0]];
      g_cpu = (m_who == 1); g_ccd = (m_who == 2); g_acc = (m_who == 3);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int          beats, ccd_left, ccd_idx, acc_left, acc_idx;
  bit          cpu_done;
  logic [15:0] ccd_base, acc_base;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_idle", 32'({cpu_gnt, ccd_gnt, acc_gnt, mem_en}), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);

    // CPU read of a preloaded word.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    #1;
    chk("A_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("A_stall", 32'(cpu_stall), 32'd0);
    nxt();
    cpu_req = 0;
    #1;
    chk("A_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("A_rdata", 32'(mem_rdata), 32'h1234);

    // CPU and single-beat CCD together: CPU first, CCD next cycle.
    nxt();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
    ccd_req = 1; ccd_last = 1; ccd_addr = 16'h0020; ccd_wdata = 16'hbeef;
    #1;
    chk("B_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("B_ccd_wait", 32'(ccd_gnt), 32'd0);
    chk("B_stall", 32'(cpu_stall), 32'd0);
    nxt();
    cpu_req = 0;
    #1;
    chk("B_ccd_gnt", 32'(ccd_gnt), 32'd1);
    chk("B_mem_we", 32'(mem_we), 32'd1);
    chk("B_wdata", 32'(mem_wdata), 32'hbeef);
    nxt();
    ccd_req = 0;

    // Fresh reset, then both DMA ports single-beat: strict alternation from CCD.
    rst_n = 0;
    nxt(); nxt();
    rst_n = 1;
    ccd_req = 1; ccd_last = 1; acc_req = 1; acc_last = 1; acc_we = 1;
    for (int i = 0; i < 4; i++) begin
      ccd_addr = 16'(8'h60 + i); ccd_wdata = 16'(i); acc_addr = 16'(8'h70 + i);
      acc_wdata = 16'(100 + i);
      #1;
      chk("D_ccd", 32'(ccd_gnt), 32'(i % 2 == 0));
      chk("D_acc", 32'(acc_gnt), 32'(i % 2 == 1));
      nxt();
    end
    ccd_req = 0; acc_req = 0;
    nxt();

    // 12-beat ACC read burst, CPU read waiting from cycle 2: forced in at cycle 8.
    beats = 0; cpu_done = 0;
    for (int c = 0; c < 14; c++) begin
      acc_req = (beats < 12); acc_we = 0; acc_last = (beats == 11);
      acc_addr = 16'(64 + beats);
      cpu_req = (c >= 2) && !cpu_done; cpu_we = 0; cpu_addr = 16'h0010;
      #1;
      chk("C_acc", 32'(acc_gnt), 32'((c <= 7) || (c >= 9 && c <= 12)));
      chk("C_cpu", 32'(cpu_gnt), 32'(c == 8));
      chk("C_stall", 32'(cpu_stall), 32'(c >= 2 && c <= 7));
      chk("C_rvalid", 32'(acc_rvalid), 32'((c >= 1 && c <= 8) || (c >= 10)));
      if (acc_gnt) beats++;
      if (cpu_gnt) cpu_done = 1;
      nxt();
    end
    acc_req = 0; cpu_req = 0;

    // ACC burst with a gap at beat 3: CPU slips in, CCD locked out, count holds at 3.
    ccd_last = 1; ccd_addr = 16'h0080; ccd_wdata = 16'h0ccd; acc_we = 1;
    for (int c = 0; c < 13; c++) begin
      acc_req  = (c <= 2) || (c >= 5 && c <= 11);
      acc_last = (c >= 10);
      acc_addr = 16'(144 + c); acc_wdata = 16'(c);
      cpu_req  = (c == 3) || (c >= 6 && c <= 10); cpu_we = 1; cpu_addr = 16'h0090;
      ccd_req  = (c >= 3);
      #1;
      chk("E_cpu", 32'(cpu_gnt), 32'(c == 3 || c == 10));
      chk("E_acc", 32'(acc_gnt), 32'((c <= 2) || (c >= 5 && c <= 9) || c == 11));
      chk("E_ccd", 32'(ccd_gnt), 32'(c == 12));
      chk("E_stall", 32'(cpu_stall), 32'(c >= 6 && c <= 9));
      nxt();
    end
    ccd_req = 0; acc_req = 0; cpu_req = 0;
    nxt();

    // Reset mid-burst with a read in flight.
    acc_req = 1; acc_we = 0; acc_last = 0; acc_addr = 16'h00a0;
    nxt();
    acc_addr = 16'h00a1;
    nxt();
    chk("F_rv_pre", 32'(acc_rvalid), 32'd1);
    rst_n = 0; acc_req = 0;
    #1;
    chk("F_rvalid", 32'(acc_rvalid), 32'd0);
    nxt();
    rst_n = 1;
    ccd_req = 1; ccd_last = 1; ccd_addr = 16'h00b0; ccd_wdata = 16'h7777;
    #1;
    chk("F_ccd", 32'(ccd_gnt), 32'd1);
    nxt();
    ccd_req = 0;

    // Randomized traffic: requesters hold until granted, DMA bursts of 1..12 with gaps.
    ccd_left = 0; acc_left = 0; ccd_idx = 0; acc_idx = 0; ccd_base = '0; acc_base = '0;
    for (int n = 0; n < 4000; n++) begin
      nxt();
      if (!(cpu_req && !g_cpu)) begin
        cpu_req   = ($urandom_range(0, 99) < 40);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 255));
        cpu_wdata = 16'($urandom);
      end
      if (ccd_req && g_ccd) begin ccd_left--; ccd_idx++; end
      if (!(ccd_req && !g_ccd)) begin
        if (ccd_left == 0 && $urandom_range(0, 99) < 30) begin
          ccd_left = $urandom_range(1, 12); ccd_idx = 0;
          ccd_base = 16'($urandom_range(0, 240));
        end
        ccd_req   = (ccd_left > 0) && ($urandom_range(0, 99) < 80);
        ccd_last  = (ccd_left == 1);
        ccd_addr  = ccd_base + 16'(ccd_idx);
        ccd_wdata = 16'($urandom);
      end
      if (acc_req && g_acc) begin acc_left--; acc_idx++; end
      if (!(acc_req && !g_acc)) begin
        if (acc_left == 0 && $urandom_range(0, 99) < 30) begin
          acc_left = $urandom_range(1, 12); acc_idx = 0;
          acc_base = 16'($urandom_range(0, 240));
          acc_we   = 1'($urandom_range(0, 1));
        end
        acc_req   = (acc_left > 0) && ($urandom_range(0, 99) < 80);
        acc_last  = (acc_left == 1);
        acc_addr  = acc_base + 16'(acc_idx);
        acc_wdata = 16'($urandom);
      end
    end
    cpu_req = 0; ccd_req = 0; acc_req = 0;
    repeat (3) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
